ones_count_seq: RTL and testbench
=================================

Name: ones_count_seq

Overview:
- Sequential, parametrised successor to the combinational 15-input ones counter.
- Accepts one WIDTH-bit word per valid/ready handshake and scans it LANES bits per cycle.
- Returns the ones (or zeros) count of the word, a majority flag, and a saturating per-frame running total.
- Sits between a word source and a downstream consumer; both sides are fully back-pressurable.

Parameters:
- WIDTH, 15, bits per input word (>=1).
- LANES, 4, bits examined per SCAN cycle (1..WIDTH; values above WIDTH behave as WIDTH).
- ACC_W, 8, frame accumulator width (>=CNT_W).
- CNT_W (localparam), $clog2(WIDTH+1), count width.
- C (localparam), ceil(WIDTH/LANES), number of SCAN cycles.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  source has a word.
- in_ready  out  1  block can accept a word.
- in_data  in  WIDTH  word; bit 0 is scanned first.
- in_mode  in  1  0 = count ones, 1 = count zeros.
- in_last  in  1  word is the final word of its frame.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_count  out  CNT_W  count for the current word.
- out_majority  out  1  out_count > WIDTH/2 (integer division).
- out_acc  out  ACC_W  saturating sum of out_count over the frame so far, including the current word.
- out_acc_sat  out  1  sticky flag: accumulator saturated within the current frame.
- out_last  out  1  registered copy of in_last.

Behaviour:
- Reset (async assert, sync deassert at the consumer's discretion):
  - FSM goes to IDLE.
  - Output values: in_ready=1; out_valid=0; out_count=0; out_majority=0; out_acc=0; out_acc_sat=0; out_last=0.
  - Internal pointer, partial count and latched word are cleared.
  - A reset during SCAN or HOLD abandons the word and the frame total.
- FSM states: IDLE, SCAN, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_data (XOR-inverted when in_mode=1), in_last; set ptr=0, partial=0; go to SCAN.
- SCAN:
  - in_ready=0.
  - Each cycle: partial += popcount(latched[ptr +: LANES]), with bits at index >= WIDTH masked to 0; ptr += LANES.
  - After the C-th cycle, register the following and go to HOLD:
    - out_count = final partial.
    - out_majority.
    - out_acc = min(acc + out_count, 2^ACC_W - 1).
    - out_acc_sat |= overflow.
    - out_last.
- HOLD:
  - out_valid=1; in_ready=0.
  - All outputs stay stable until out_ready.
  - On out_valid&&out_ready, go to IDLE next cycle. If out_last=1, the internal frame accumulator and sat flag clear for the next word. The out_acc and out_acc_sat values stay visible until the next result is registered.
- Latency:
  - Accept edge at cycle k; out_valid rises at edge k+C.
  - Throughput is one word per C+2 cycles with out_ready held high. No overlap of accept and output.
- Boundary conditions:
  - Count range is 0..WIDTH; never wraps, since CNT_W suffices.
  - Accumulator saturates at 2^ACC_W-1, never wraps; sat stays 1 until the frame-ending handshake.
  - in_valid and in_data are ignored outside IDLE.
  - in_valid may drop without penalty.
  - in_mode and in_last are sampled only at the accept edge.
  - WIDTH=1 or LANES>=WIDTH: C=1.

Test Plan:
- WIDTH=15, LANES=4, ACC_W=8, out_ready=1:
  - in_data=bit0|bit4 (0x0011), mode 0, last 1 -> out_count=2, out_majority=0, out_acc=2, out_valid high exactly 4 cycles after the accept edge, for one cycle.
  - in_data=0x7FFF, mode 0 -> out_count=15, out_majority=1. Then in_data=0x0003, mode 1 -> out_count=13, out_majority=1. Then in_data=0x7007, mode 0 -> out_count=6, out_majority=0.
- Frame accumulation with ACC_W=5:
  - Three words 0x7FFF with last=0,0,1 -> out_acc=15, 30, 31; out_acc_sat=0, 0, 1.
  - Next word 0x0001 (last=1) -> out_acc=1, out_acc_sat=0.
- Backpressure:
  - Hold out_ready=0 for 6 cycles in HOLD -> out_valid stays 1, outputs unchanged, in_ready=0, new in_data ignored.
  - Release -> in_ready=1 on the following cycle.
- Reset mid-operation:
  - Assert rst_n=0 during the second SCAN cycle -> all outputs go to reset values immediately, without waiting for a clock edge.
  - Next word 0x00FF -> out_count=8, out_acc=8.
- Parameter sweep:
  - LANES=1, 4, 15, 16 with WIDTH=15 on 200 random words -> out_count matches the reference popcount every time.
  - Latency equals C = 15, 4, 1, 1 respectively.

Source files
------------

// File: rtl/ones_count_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : ones_count_seq_if
// Description : Word-in / result-out handshake bundle for ones_count_seq.
//               slave  - the counter block (accepts words, produces results)
//               master - the environment (word source + result consumer)
//               Input side : in_valid/in_ready, in_data, in_mode, in_last
//               Output side: out_valid/out_ready, out_count, out_majority,
//                            out_acc, out_acc_sat, out_last
// Revision    : 1.0 - initial release
// ============================================================================
interface ones_count_seq_if #(
    parameter int WIDTH = 15,
    parameter int ACC_W = 8
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_mode;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] out_count;
    logic             out_majority;
    logic [ACC_W-1:0] out_acc;
    logic             out_acc_sat;
    logic             out_last;

    modport master (
        output in_valid, in_data, in_mode, in_last, out_ready,
        input  in_ready, out_valid, out_count, out_majority, out_acc,
               out_acc_sat, out_last
    );

    modport slave (
        input  in_valid, in_data, in_mode, in_last, out_ready,
        output in_ready, out_valid, out_count, out_majority, out_acc,
               out_acc_sat, out_last
    );
endinterface
`default_nettype wire

// File: rtl/ones_count_seq.sv
`default_nettype none
// ============================================================================
// Module      : ones_count_seq
// Description : Sequential ones/zeros counter. Accepts one WIDTH-bit word per
//               handshake, scans it LANES bits per cycle (bit 0 first), then
//               presents the count, a majority flag and a saturating per-frame
//               running total until the consumer takes it.
// Ports       : clk   - rising-edge clock
//               rst_n - asynchronous active-low reset
//               bus   - ones_count_seq_if.slave (word input / result output)
// Revision    : 1.0 - initial release
// ============================================================================
module ones_count_seq #(
    parameter int WIDTH = 15,
    parameter int LANES = 4,
    parameter int ACC_W = 8
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    ones_count_seq_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int L_EFF = (LANES > WIDTH) ? WIDTH : LANES;
    localparam int C     = (WIDTH + L_EFF - 1) / L_EFF;
    localparam int PTR_W = $clog2(WIDTH + L_EFF + 1);
    localparam int SUM_W = ACC_W + 1;

    localparam logic [ACC_W-1:0] c_acc_max  = '1;
    localparam logic [CNT_W-1:0] c_half     = CNT_W'(WIDTH / 2);
    localparam logic [PTR_W-1:0] c_lanes    = PTR_W'(L_EFF);
    localparam logic [PTR_W-1:0] c_last_ptr = PTR_W'((C - 1) * L_EFF);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_scan = 2'd1;
    localparam logic [1:0] c_hold = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [WIDTH-1:0] r_word;
    logic             r_last_in;
    logic [PTR_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_partial;
    logic [ACC_W-1:0] r_acc;
    logic             r_sat;
    logic [CNT_W-1:0] r_out_count;
    logic             r_out_maj;
    logic [ACC_W-1:0] r_out_acc;
    logic             r_out_sat;
    logic             r_out_last;

    logic [L_EFF-1:0] w_lane_bits;
    logic [CNT_W-1:0] w_lane_cnt;
    logic [CNT_W-1:0] w_partial_next;
    logic             w_last_step;
    logic [SUM_W-1:0] w_sum;
    logic             w_ovf;
    logic [ACC_W-1:0] w_acc_next;
    logic             w_sat_next;
    logic             w_in_ready;
    logic             w_out_valid;

    // The right shift zero-fills, so lane bits past the top of the word are
    // naturally masked on the final (possibly partial) lane.
    always_comb begin
        w_lane_bits = L_EFF'(r_word >> r_ptr);
        w_lane_cnt  = '0;
        for (int i = 0; i < L_EFF; i++) begin
            w_lane_cnt = w_lane_cnt + CNT_W'(w_lane_bits[i]);
        end
    end

    assign w_partial_next = r_partial + w_lane_cnt;
    assign w_last_step    = (r_ptr == c_last_ptr);
    assign w_sum          = {1'b0, r_acc} + SUM_W'(w_partial_next);
    assign w_ovf          = w_sum[ACC_W];
    assign w_acc_next     = w_ovf ? c_acc_max : w_sum[ACC_W-1:0];
    assign w_sat_next     = r_sat | w_ovf;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_idle:  if (bus.in_valid)  w_state_next = c_scan;
            c_scan:  if (w_last_step)   w_state_next = c_hold;
            c_hold:  if (bus.out_ready) w_state_next = c_idle;
            default:                    w_state_next = c_idle;
        endcase
    end

    // Output decode
    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            c_idle:  w_in_ready  = 1'b1;
            c_hold:  w_out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath. The frame total (r_acc/r_sat) is kept apart from the visible
    // result registers so a frame-ending handshake can clear it while the
    // last result stays on the outputs until the next one is registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word      <= '0;
            r_last_in   <= 1'b0;
            r_ptr       <= '0;
            r_partial   <= '0;
            r_acc       <= '0;
            r_sat       <= 1'b0;
            r_out_count <= '0;
            r_out_maj   <= 1'b0;
            r_out_acc   <= '0;
            r_out_sat   <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (bus.in_valid) begin
                        // Zero counting is ones counting of the inverted word.
                        r_word    <= bus.in_mode ? ~bus.in_data : bus.in_data;
                        r_last_in <= bus.in_last;
                        r_ptr     <= '0;
                        r_partial <= '0;
                    end
                end
                c_scan: begin
                    r_ptr     <= r_ptr + c_lanes;
                    r_partial <= w_partial_next;
                    if (w_last_step) begin
                        r_out_count <= w_partial_next;
                        r_out_maj   <= (w_partial_next > c_half);
                        r_out_acc   <= w_acc_next;
                        r_out_sat   <= w_sat_next;
                        r_out_last  <= r_last_in;
                        r_acc       <= w_acc_next;
                        r_sat       <= w_sat_next;
                    end
                end
                c_hold: begin
                    if (bus.out_ready && r_out_last) begin
                        r_acc <= '0;
                        r_sat <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = w_out_valid;
    assign bus.out_count    = r_out_count;
    assign bus.out_majority = r_out_maj;
    assign bus.out_acc      = r_out_acc;
    assign bus.out_acc_sat  = r_out_sat;
    assign bus.out_last     = r_out_last;
endmodule
`default_nettype wire

// File: tb/tb_ones_count_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_ones_count_seq
// Description : Self-checking bench for ones_count_seq. Five instances share
//               clk/rst_n: WIDTH=15 with LANES=1/4/15/16 (ACC_W=8) and
//               LANES=4 with ACC_W=5. Each result is compared with a
//               reference model built from popcounts and integer sums.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ones_count_seq;
    localparam int NDUT  = 5;
    localparam int WIDTH = 15;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NDUT-1:0]            s_valid;
    logic [NDUT-1:0]            s_mode;
    logic [NDUT-1:0]            s_last;
    logic [NDUT-1:0]            s_ordy;
    logic [NDUT-1:0][WIDTH-1:0] s_data;

    wire  [NDUT-1:0]            w_in_ready;
    wire  [NDUT-1:0]            w_out_valid;
    wire  [NDUT-1:0]            w_maj;
    wire  [NDUT-1:0]            w_sat;
    wire  [NDUT-1:0]            w_olast;
    wire  [NDUT-1:0][3:0]       w_cnt;
    wire  [NDUT-1:0][7:0]       w_acc;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int LN = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 15 : (g == 3) ? 16 : 4;
        localparam int AW = (g == 4) ? 5 : 8;

        ones_count_seq_if #(.WIDTH(WIDTH), .ACC_W(AW)) bus ();

        assign bus.in_valid  = s_valid[g];
        assign bus.in_data   = s_data[g];
        assign bus.in_mode   = s_mode[g];
        assign bus.in_last   = s_last[g];
        assign bus.out_ready = s_ordy[g];

        assign w_in_ready[g]  = bus.in_ready;
        assign w_out_valid[g] = bus.out_valid;
        assign w_cnt[g]       = bus.out_count;
        assign w_maj[g]       = bus.out_majority;
        assign w_acc[g]       = 8'(bus.out_acc);
        assign w_sat[g]       = bus.out_acc_sat;
        assign w_olast[g]     = bus.out_last;

        ones_count_seq #(.WIDTH(WIDTH), .LANES(LN), .ACC_W(AW)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus.slave)
        );
    end

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state: running frame total per instance
    int m_acc       [NDUT];
    bit m_sat       [NDUT];
    bit m_pend_last [NDUT];

    function automatic int c_of(input int d);
        case (d)
            0:       return 15;
            1:       return 4;
            2:       return 1;
            3:       return 1;
            default: return 4;
        endcase
    endfunction

    function automatic int acc_max(input int d);
        return (d == 4) ? 31 : 255;
    endfunction

    function automatic logic [16:0] snapshot(input int d);
        return {w_in_ready[d], w_out_valid[d], w_cnt[d], w_maj[d], w_acc[d], w_sat[d], w_olast[d]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NDUT; i++) begin
            m_acc[i]       = 0;
            m_sat[i]       = 1'b0;
            m_pend_last[i] = 1'b0;
        end
    endtask

    // Offer a word, wait for the result and compare it with the model.
    task automatic issue(input int d, input logic [WIDTH-1:0] data, input logic mode,
                         input logic last, output logic [3:0] cnt, output logic [7:0] acc,
                         output logic sat);
        int n;
        int ec;
        int sum;
        bit ovf;
        @(negedge clk);
        s_valid[d] = 1'b1;
        s_data[d]  = data;
        s_mode[d]  = mode;
        s_last[d]  = last;
        n = 0;
        while (!w_in_ready[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("accept_wait_d%0d", d), 32'(n < 50), 32'd1);
        @(posedge clk);
        #1;
        // Garbage after the accept edge must not influence the result
        s_valid[d] = 1'b0;
        s_data[d]  = WIDTH'($urandom);
        s_mode[d]  = 1'($urandom);
        s_last[d]  = 1'($urandom);
        n = 0;
        while (!w_out_valid[d] && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        ec  = mode ? WIDTH - $countones(data) : $countones(data);
        sum = m_acc[d] + ec;
        ovf = (sum > acc_max(d));
        m_acc[d]       = ovf ? acc_max(d) : sum;
        m_sat[d]       = m_sat[d] | ovf;
        m_pend_last[d] = last;
        check($sformatf("latency_d%0d", d), 32'(n), 32'(c_of(d)));
        check($sformatf("count_d%0d_%h_m%0d", d, data, mode), 32'(w_cnt[d]), 32'(ec));
        check($sformatf("majority_d%0d", d), 32'(w_maj[d]), 32'(ec > WIDTH / 2));
        check($sformatf("acc_d%0d", d), 32'(w_acc[d]), 32'(m_acc[d]));
        check($sformatf("acc_sat_d%0d", d), 32'(w_sat[d]), 32'(m_sat[d]));
        check($sformatf("out_last_d%0d", d), 32'(w_olast[d]), 32'(last));
        cnt = w_cnt[d];
        acc = w_acc[d];
        sat = w_sat[d];
    endtask

    // Consumer takes the result; out_valid must fall and in_ready rise.
    task automatic retire(input int d);
        @(negedge clk);
        s_ordy[d] = 1'b1;
        @(posedge clk);
        #1;
        check($sformatf("valid_drop_d%0d", d), 32'(w_out_valid[d]), 32'd0);
        check($sformatf("ready_back_d%0d", d), 32'(w_in_ready[d]), 32'd1);
        if (m_pend_last[d]) begin
            m_acc[d] = 0;
            m_sat[d] = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0]  cnt;
        logic [7:0]  acc;
        logic        sat;
        logic [16:0] snap;

        s_valid = '0;
        s_mode  = '0;
        s_last  = '0;
        s_ordy  = '1;
        s_data  = '0;
        rst_n   = 1'b0;
        model_reset();

        // Reset values on every instance
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("reset_state_d%0d", d), 32'(snapshot(d)), 32'h10000);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Directed words, LANES=4
        issue(1, 15'h0011, 1'b0, 1'b1, cnt, acc, sat);
        check("dir_0011_count", 32'(cnt), 32'd2);
        check("dir_0011_acc", 32'(acc), 32'd2);
        retire(1);
        issue(1, 15'h7FFF, 1'b0, 1'b1, cnt, acc, sat);
        check("dir_7fff_count", 32'(cnt), 32'd15);
        retire(1);
        issue(1, 15'h0003, 1'b1, 1'b1, cnt, acc, sat);
        check("dir_0003_zeros", 32'(cnt), 32'd13);
        retire(1);
        issue(1, 15'h7007, 1'b0, 1'b1, cnt, acc, sat);
        check("dir_7007_count", 32'(cnt), 32'd6);
        retire(1);

        // Frame accumulation with ACC_W=5
        issue(4, 15'h7FFF, 1'b0, 1'b0, cnt, acc, sat);
        check("acc5_w1", 32'(acc), 32'd15);
        check("acc5_w1_sat", 32'(sat), 32'd0);
        retire(4);
        issue(4, 15'h7FFF, 1'b0, 1'b0, cnt, acc, sat);
        check("acc5_w2", 32'(acc), 32'd30);
        check("acc5_w2_sat", 32'(sat), 32'd0);
        retire(4);
        issue(4, 15'h7FFF, 1'b0, 1'b1, cnt, acc, sat);
        check("acc5_w3", 32'(acc), 32'd31);
        check("acc5_w3_sat", 32'(sat), 32'd1);
        retire(4);
        issue(4, 15'h0001, 1'b0, 1'b1, cnt, acc, sat);
        check("acc5_new_frame", 32'(acc), 32'd1);
        check("acc5_new_frame_sat", 32'(sat), 32'd0);
        retire(4);

        // Backpressure: result held for 6 cycles while new words are offered
        s_ordy[1] = 1'b0;
        issue(1, 15'h1234, 1'b0, 1'b0, cnt, acc, sat);
        snap = snapshot(1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            s_valid[1] = 1'b1;
            s_data[1]  = WIDTH'($urandom);
            @(posedge clk);
            #1;
            check($sformatf("bp_hold_%0d", i), 32'(snapshot(1)), 32'(snap));
        end
        s_valid[1] = 1'b0;
        retire(1);

        // Reset during the second SCAN cycle
        @(negedge clk);
        s_valid[1] = 1'b1;
        s_data[1]  = 15'h7FFF;
        s_mode[1]  = 1'b0;
        s_last[1]  = 1'b0;
        @(posedge clk);
        #1;
        s_valid[1] = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 32'(snapshot(1)), 32'h10000);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        issue(1, 15'h00FF, 1'b0, 1'b1, cnt, acc, sat);
        check("post_reset_count", 32'(cnt), 32'd8);
        check("post_reset_acc", 32'(acc), 32'd8);
        retire(1);

        // Random sweep over LANES = 1, 4, 15, 16
        for (int d = 0; d < 4; d++) begin
            for (int k = 0; k < 200; k++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                issue(d, WIDTH'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0), cnt, acc, sat);
                retire(d);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
